hawkes_intensity: RTL and testbench

Computes the Hawkes-process conditional intensity λ(t) = μ + Σ α·exp(−β·(t − tᵢ)) for the Monte Carlo thinning loop. The block keeps a circular buffer of past event times and forms each kernel argument in Q2.8. It drives the `expon` unit once per stored event through its `start`/`done` handshake, then accumulates the weighted results. It sits directly upstream of `expon`, feeding it arguments and consuming its outputs, and hands λ to the accept/reject comparator.

---
 rtl/hawkes_intensity.sv | 158 +++++++++++++++
 tb/tb_hawkes_intensity.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hawkes_intensity.sv
// Hawkes conditional intensity: lambda = mu + sum(alpha * exp(-beta * (t - t_i))).
// Scans a circular event buffer and drives one expon evaluation per kept event.
module hawkes_intensity #(
    parameter int N_EVT = 8,
    parameter int T_W   = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           evt_push,
    input  logic [T_W-1:0] evt_time,
    output logic           evt_ready,
    input  logic           req,
    input  logic [T_W-1:0] t_now,
    input  logic [9:0]     mu,
    input  logic [9:0]     alpha,
    input  logic [9:0]     beta,
    output logic [9:0]     exp_x,
    output logic           exp_start,
    input  logic [9:0]     exp_y,
    input  logic           exp_done,
    output logic [11:0]    lambda,
    output logic           lambda_valid,
    output logic           busy
);
    localparam int PW     = $clog2(N_EVT);
    localparam int PROD_W = T_W + 10;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(N_EVT);
    localparam logic [9:0]  ARG_MAX  = 10'd317;

    typedef enum logic [2:0] {S_IDLE, S_ARG, S_ISSUE, S_WAIT, S_ACC, S_DONE} state_t;

    function automatic logic [9:0] sat_arg(input logic [PROD_W-1:0] p);
        if (|p[PROD_W-1:18]) return 10'd1023;
        return p[17:8];
    endfunction

    function automatic logic [11:0] sat_acc(input logic [11:0] a, input logic [9:0] t);
        logic [12:0] s;
        s = {1'b0, a} + {3'b000, t};
        return s[12] ? 12'hFFF : s[11:0];
    endfunction

    state_t              r_state, w_state_nxt;
    logic [T_W-1:0]      r_mem [N_EVT];
    logic [PW-1:0]       r_rd_ptr, r_wr_ptr, r_idx;
    logic [PW:0]         r_count, r_rem;
    logic                r_wait_first, r_exp_start, r_lambda_valid, r_busy, r_evt_ready;
    logic signed [9:0]   r_exp_x;
    logic [11:0]         r_lambda, r_acc;
    logic [T_W-1:0]      r_t_now;
    logic [9:0]          r_alpha, r_beta, r_y;

    logic                w_push, w_accept, w_full, w_trunc, w_evict, w_issue;
    logic [T_W-1:0]      w_ti, w_delta;
    logic [PROD_W-1:0]   w_prod;
    logic [9:0]          w_arg, w_term;
    logic [19:0]         w_wprod;

    assign w_full   = (r_count == FULL_CNT);
    assign w_push   = evt_push && (r_state == S_IDLE);
    assign w_accept = req && (r_state == S_IDLE);

    // Argument stage: kernel argument for the entry under the scan index
    assign w_ti    = r_mem[r_idx];
    assign w_delta = (w_ti > r_t_now) ? '0 : (r_t_now - w_ti);
    assign w_prod  = PROD_W'(r_beta) * PROD_W'(w_delta);
    assign w_arg   = sat_arg(w_prod);
    assign w_trunc = (w_arg > ARG_MAX);
    assign w_evict = (r_state == S_ARG) && (r_rem != '0) && w_trunc;
    assign w_issue = (r_state == S_ARG) && (w_state_nxt == S_ISSUE);

    // Accumulate stage: weighted kernel term
    assign w_wprod = 20'(r_alpha) * 20'(r_y);
    assign w_term  = w_wprod[17:8];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req) w_state_nxt = S_ARG;
            S_ARG: begin
                if (r_rem == '0)   w_state_nxt = S_DONE;
                else if (!w_trunc) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            // expon clears done on the start edge, so the first WAIT sample is stale
            S_WAIT:  if (!r_wait_first && exp_done) w_state_nxt = S_ACC;
            S_ACC:   w_state_nxt = S_ARG;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_count        <= '0;
            r_idx          <= '0;
            r_rem          <= '0;
            r_wait_first   <= 1'b0;
            r_exp_start    <= 1'b0;
            r_exp_x        <= '0;
            r_lambda       <= '0;
            r_lambda_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_evt_ready    <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_busy         <= (w_state_nxt != S_IDLE);
            r_evt_ready    <= (w_state_nxt == S_IDLE);
            r_exp_start    <= w_issue;
            r_wait_first   <= (r_state == S_ISSUE);
            r_lambda_valid <= (r_state == S_DONE);
            if (r_state == S_DONE) r_lambda <= r_acc;
            if (w_issue) r_exp_x <= -$signed(w_arg);

            // Push and eviction are exclusive: pushes only land in IDLE
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_full) r_rd_ptr <= r_rd_ptr + 1'b1;
                else        r_count  <= r_count + 1'b1;
            end else if (w_evict) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end

            if (w_accept) begin
                r_idx <= (w_push && w_full) ? (r_rd_ptr + 1'b1) : r_rd_ptr;
                r_rem <= (w_push && !w_full) ? (r_count + 1'b1) : r_count;
            end else if (w_evict || (r_state == S_ACC)) begin
                r_idx <= r_idx + 1'b1;
                r_rem <= r_rem - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= evt_time;
        if (w_accept) begin
            r_t_now <= t_now;
            r_alpha <= alpha;
            r_beta  <= beta;
            r_acc   <= {2'b00, mu};
        end else if (r_state == S_ACC) begin
            r_acc <= sat_acc(r_acc, w_term);
        end
        if ((r_state == S_WAIT) && !r_wait_first && exp_done) r_y <= exp_y;
    end

    assign evt_ready    = r_evt_ready;
    assign busy         = r_busy;
    assign exp_start    = r_exp_start;
    assign exp_x        = r_exp_x;
    assign lambda       = r_lambda;
    assign lambda_valid = r_lambda_valid;

endmodule

// File: tb/tb_hawkes_intensity.sv
// Directed bench for hawkes_intensity with a behavioural expon responder.
module tb_hawkes_intensity;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        evt_push = 1'b0;
    logic [15:0] evt_time = '0;
    logic        evt_ready;
    logic        req = 1'b0;
    logic [15:0] t_now = '0;
    logic [9:0]  mu = '0, alpha = '0, beta = '0;
    logic [9:0]  exp_x;
    logic        exp_start;
    logic [9:0]  exp_y = '0;
    logic        exp_done = 1'b0;
    logic [11:0] lambda;
    logic        lambda_valid;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    hawkes_intensity #(.N_EVT(8), .T_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .evt_push(evt_push), .evt_time(evt_time), .evt_ready(evt_ready),
        .req(req), .t_now(t_now), .mu(mu), .alpha(alpha), .beta(beta),
        .exp_x(exp_x), .exp_start(exp_start), .exp_y(exp_y), .exp_done(exp_done),
        .lambda(lambda), .lambda_valid(lambda_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // expon responder: done drops on start, rises m_lat negedges later with m_y
    int m_lat = 4;
    int m_y = 0;
    int m_cnt = 0;
    int n_pulses = 0;
    logic [9:0] q_x[$];

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_done = 1'b0;
            m_cnt = 0;
        end else if (exp_start) begin
            exp_done = 1'b0;
            m_cnt = m_lat;
            n_pulses++;
            q_x.push_back(exp_x);
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                exp_done = 1'b1;
                exp_y = 10'(m_y);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_evt(input int t);
        @(negedge clk);
        evt_push = 1'b1;
        evt_time = 16'(t);
        @(negedge clk);
        evt_push = 1'b0;
    endtask

    task automatic do_req(input int tn, input int m, input int al, input int be,
                          input int y, input int lt,
                          output int lam, output int latc, output int np, output int qb);
        int base;
        @(negedge clk);
        m_y = y;
        m_lat = lt;
        base = n_pulses;
        qb = q_x.size();
        t_now = 16'(tn);
        mu = 10'(m);
        alpha = 10'(al);
        beta = 10'(be);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        mu = 10'd999;
        alpha = 10'd0;
        beta = 10'd1023;
        chk("busy_after_req", int'(busy), 1);
        latc = -1;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk);
            #1;
            if (lambda_valid) begin
                latc = k;
                break;
            end
        end
        lam = int'(lambda);
        np = n_pulses - base;
    endtask

    typedef struct {
        int n, t0, tstep, tnow, m, al, be, y, lat;
        int e_lam, e_np, e_x0, e_lat, e_absent;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int lam, latc, np, qb, hits, cnt;
        tbl[0]  = '{0,   0,   0,   500,   128,    0,    0,   0, 4,  128, 0,   0,  2,  -1};
        tbl[1]  = '{1,   0,   0,   128,   128,  256,  256, 155, 4,  283, 1, 896,  9,  -1};
        tbl[2]  = '{1,   0,   0,   400,    77,  256,  256,   0, 4,   77, 0,   0,  3,  -1};
        tbl[3]  = '{8, 300,   0,   300,  1000, 1023,  256, 256, 4, 4095, 8,   0, 58,  -1};
        tbl[4]  = '{9,   0,  10,   100,     0,  256,  256, 128, 4, 1024, 8, 934, 58, 924};
        tbl[5]  = '{2,   0, 300,   400,    50,  512,  256, 100, 4,  250, 1, 924, 10,  -1};
        tbl[6]  = '{1,   0,   0,   256,     5,  128,   64, 200, 2,  105, 1, 960,  7,  -1};
        tbl[7]  = '{1, 200,   0,   100,     0,  256,  256, 256, 4,  256, 1,   0,  9,  -1};
        tbl[8]  = '{1,   0,   0, 65535,     3,  256, 1023,   0, 4,    3, 0,   0,  3,  -1};
        tbl[9]  = '{1,   0,   0,   317,     0,  256,  256,  73, 4,   73, 1, 707,  9,  -1};
        tbl[10] = '{1,   0,   0,   318,     9,  256,  256,   0, 4,    9, 0,   0,  3,  -1};

        #3 rst_n = 1'b0;
        #4;
        chk("rst_lambda", int'(lambda), 0);
        chk("rst_lambda_valid", int'(lambda_valid), 0);
        chk("rst_exp_start", int'(exp_start), 0);
        chk("rst_exp_x", int'(exp_x), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_evt_ready", int'(evt_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            do_reset();
            for (int k = 0; k < tbl[i].n; k++) push_evt(tbl[i].t0 + k * tbl[i].tstep);
            do_req(tbl[i].tnow, tbl[i].m, tbl[i].al, tbl[i].be, tbl[i].y, tbl[i].lat,
                   lam, latc, np, qb);
            chk($sformatf("v%0d_lambda", i), lam, tbl[i].e_lam);
            chk($sformatf("v%0d_latency", i), latc, tbl[i].e_lat);
            chk($sformatf("v%0d_pulses", i), np, tbl[i].e_np);
            if (np > 0 && tbl[i].e_np > 0)
                chk($sformatf("v%0d_first_x", i), int'(q_x[qb]), tbl[i].e_x0);
            if (tbl[i].e_absent >= 0) begin
                hits = 0;
                for (int k = qb; k < q_x.size(); k++)
                    if (int'(q_x[k]) == tbl[i].e_absent) hits++;
                chk($sformatf("v%0d_oldest_absent", i), hits, 0);
            end
        end

        // Truncated head is evicted: the next request sees an empty buffer
        do_reset();
        push_evt(0);
        do_req(400, 77, 256, 256, 0, 4, lam, latc, np, qb);
        chk("trunc1_lambda", lam, 77);
        do_req(400, 88, 256, 256, 0, 4, lam, latc, np, qb);
        chk("trunc2_lambda", lam, 88);
        chk("trunc2_latency", latc, 2);
        chk("trunc2_pulses", np, 0);

        // Push together with req, then a push while busy
        do_reset();
        @(negedge clk);
        m_y = 200;
        m_lat = 4;
        cnt = n_pulses;
        evt_push = 1'b1;
        evt_time = 16'd50;
        req = 1'b1;
        t_now = 16'd50;
        mu = 10'd10;
        alpha = 10'd256;
        beta = 10'd256;
        @(negedge clk);
        req = 1'b0;
        evt_time = 16'd60;
        @(negedge clk);
        evt_push = 1'b0;
        latc = -1;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (lambda_valid) begin
                latc = k;
                break;
            end
        end
        chk("same_cycle_timeout", int'(latc >= 0), 1);
        chk("same_cycle_lambda", int'(lambda), 210);
        chk("same_cycle_pulses", n_pulses - cnt, 1);
        do_req(60, 0, 256, 256, 200, 4, lam, latc, np, qb);
        chk("busy_push_pulses", np, 1);
        chk("busy_push_lambda", lam, 200);
        if (np > 0) chk("busy_push_x", int'(q_x[qb]), 1014);

        // Reset while waiting on expon
        do_reset();
        push_evt(0);
        @(negedge clk);
        m_y = 155;
        m_lat = 10;
        cnt = n_pulses;
        t_now = 16'd128;
        mu = 10'd128;
        alpha = 10'd256;
        beta = 10'd256;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        hits = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (n_pulses != cnt) begin
                hits = 1;
                break;
            end
        end
        chk("midrst_pulse_seen", hits, 1);
        chk("midrst_exp_x_before", int'(exp_x), 896);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_lambda", int'(lambda), 0);
        chk("midrst_lambda_valid", int'(lambda_valid), 0);
        chk("midrst_exp_start", int'(exp_start), 0);
        chk("midrst_exp_x", int'(exp_x), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_evt_ready", int'(evt_ready), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (lambda_valid) cnt++;
        end
        chk("midrst_no_valid", cnt, 0);
        do_req(500, 64, 0, 0, 0, 4, lam, latc, np, qb);
        chk("post_rst_lambda", lam, 64);
        chk("post_rst_latency", latc, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
